mpls_egress_demux: RTL and testbench
====================================

MPLS_EGRESS_DEMUX -- requirements
Module: mpls_egress_demux

Interface
REQ-001 Parameter NUM_EGR_PORTS, default 4: number of egress physical ports; legal range 1..16.
REQ-002 Parameter DATA_BYTES, default 64: converged egress bus width in bytes.
REQ-003 Parameter IDX_W, default $clog2(NUM_EGR_PORTS) with a minimum of 1: egress port index width.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high (clk_ifc.clk, sreset_ifc.reset).
REQ-005 clk_ifc.clk  in  1  core clock; all logic on the rising edge.
REQ-006 sreset_ifc.reset  in  1  synchronous active-high reset.
REQ-007 s_tvalid / s_tready  in / out  1 / 1  converged egress bus handshake.
REQ-008 s_tdata / s_tkeep / s_tlast  in  8*DATA_BYTES / DATA_BYTES / 1  converged bus payload.
REQ-009 s_tuser  in  IDX_W  destination egress port index; sampled only on the first beat of a packet.
REQ-010 egr_port_enable  in  NUM_EGR_PORTS  per-port enable; sampled only on the first beat of a packet.
REQ-011 m_tvalid / m_tready  out / in  NUM_EGR_PORTS each  per-port handshake.
REQ-012 m_tdata / m_tkeep / m_tlast  out  8*DATA_BYTES / DATA_BYTES / 1  shared by all ports; meaningful only where m_tvalid[i]=1.
REQ-013 fwd_pkt_count / drop_pkt_count  out  32 / 32  saturating packet counters.
REQ-014 drop_pulse  out  1  one-cycle pulse when a dropped packet's tlast beat is consumed.

Function
REQ-015 Packet state machine SHALL have three states: SOP, FWD and DROP.
REQ-016 In SOP, a beat accepted with s_tuser<NUM_EGR_PORTS and egr_port_enable[s_tuser]=1 SHALL latch s_tuser as sel and be forwarded.
- If that beat has tlast=0, the next state is FWD; otherwise the state stays SOP.
REQ-017 In SOP, a beat accepted with s_tuser>=NUM_EGR_PORTS or with the port disabled SHALL be discarded.
- If that beat has tlast=0, the next state is DROP; otherwise the state stays SOP.
REQ-018 In FWD, accepted beats go to sel and s_tuser/egr_port_enable are ignored; the accepted tlast beat returns the state to SOP.
REQ-019 In DROP, s_tready=1 and beats are discarded; the accepted tlast beat returns the state to SOP.
REQ-020 Output SHALL be a one-entry register stage (out_valid, out_sel, data, keep, last).
- Latency from an accepted s_ beat to m_tvalid[out_sel]=1 is 1 cycle.
REQ-021 m_tvalid[i] = out_valid && (out_sel==i); at most one bit of m_tvalid SHALL be set at any time.
REQ-022 In SOP and FWD, s_tready = !out_valid || m_tready[out_sel], combinational with no bubble.
- Full throughput: one beat per cycle while the destination m_tready is held high.
REQ-023 A new packet to a different port SHALL load the register in the same cycle the previous packet's tlast beat is consumed.
- No idle cycle is inserted between packets.
REQ-024 m_tready[j] for j!=out_sel SHALL be ignored; backpressure on one port stalls the whole bus (no per-port buffering).
REQ-025 Output data/keep/last SHALL hold stable while m_tvalid[out_sel]=1 and m_tready[out_sel]=0.
REQ-026 fwd_pkt_count SHALL increment when a forwarded tlast beat is accepted on s_; drop_pkt_count and drop_pulse SHALL act when a dropped tlast beat is accepted.
- Both counters saturate at 0xFFFFFFFF with no wrap.
REQ-027 A single-beat packet (tlast on its first beat) SHALL be routed or dropped per REQ-016/017 and leave the state in SOP.
REQ-028 A change of egr_port_enable mid-packet SHALL not affect the packet in progress.

Reset
REQ-029 Reset SHALL set state=SOP and out_valid=0, so m_tvalid=0 on all ports.
REQ-030 Reset SHALL clear sel, out_sel and both counters, and set drop_pulse=0.
REQ-031 s_tready SHALL be 0 during the reset cycle and 1 in the first cycle after reset deasserts.
REQ-032 Reset asserted mid-packet SHALL discard the register stage and the partial packet.
- The next beat accepted after reset is treated as a first beat (SOP).

Verification
REQ-033 Scenario: 3-beat packet, s_tuser=2, all m_tready=1.
- m_tvalid=4'b0100 for 3 consecutive cycles starting 1 cycle after the first s_ beat; m_tlast on the third; fwd_pkt_count=1.
REQ-034 Scenario: back-to-back 2-beat packets to ports 0 then 3, no gaps.
- m_tvalid sequence 0001,0001,1000,1000 with no bubble; s_tready constant 1.
REQ-035 Scenario: packet with s_tuser=5 (NUM_EGR_PORTS=4), and a packet to port 1 with egr_port_enable[1]=0.
- All beats accepted; m_tvalid stays 0; drop_pkt_count=2; two drop_pulse pulses.
REQ-036 Scenario: m_tready[1]=0 for 5 cycles during a packet to port 1, while m_tready[0]=1.
- s_tready=0 after the register fills; m_tdata held constant; resumes with no beat lost or duplicated.
REQ-037 Scenario: reset asserted on beat 2 of a 4-beat packet.
- Next cycle m_tvalid=0 and counters=0; a following 1-beat packet to port 0 is delivered correctly.
REQ-038 Scenario: fwd_pkt_count forced to 0xFFFFFFFE, then 3 packets forwarded.
- Counter reads 0xFFFFFFFF after each of the last two packets.

Source files
------------

// File: rtl/mpls_egress_demux.sv
// MPLS egress demultiplexer: steers packets from one converged AXI-Stream bus to
// per-port outputs through a single shared register stage, dropping misrouted packets.
module mpls_egress_demux #(
    parameter int NUM_EGR_PORTS = 4,
    parameter int DATA_BYTES    = 64,
    parameter int IDX_W         = (NUM_EGR_PORTS > 1) ? $clog2(NUM_EGR_PORTS) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      s_tvalid_i,
    output logic                      s_tready_o,
    input  logic [8*DATA_BYTES-1:0]   s_tdata_i,
    input  logic [DATA_BYTES-1:0]     s_tkeep_i,
    input  logic                      s_tlast_i,
    input  logic [IDX_W-1:0]          s_tuser_i,
    input  logic [NUM_EGR_PORTS-1:0]  egr_port_enable_i,
    output logic [NUM_EGR_PORTS-1:0]  m_tvalid_o,
    input  logic [NUM_EGR_PORTS-1:0]  m_tready_i,
    output logic [8*DATA_BYTES-1:0]   m_tdata_o,
    output logic [DATA_BYTES-1:0]     m_tkeep_o,
    output logic                      m_tlast_o,
    output logic [31:0]               fwd_pkt_count_o,
    output logic [31:0]               drop_pkt_count_o,
    output logic                      drop_pulse_o
);

    typedef enum logic [1:0] {
        ST_SOP  = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          sel_q, sel_d;
    logic                      out_valid_q, out_valid_d;
    logic [IDX_W-1:0]          out_sel_q, out_sel_d;
    logic [8*DATA_BYTES-1:0]   data_q, data_d;
    logic [DATA_BYTES-1:0]     keep_q, keep_d;
    logic                      last_q, last_d;
    logic [31:0]               fwd_cnt_q, fwd_cnt_d;
    logic [31:0]               drop_cnt_q, drop_cnt_d;
    logic                      drop_pulse_q, drop_pulse_d;

    logic                      port_en_s;
    logic                      out_ready_s;
    logic                      s_tready_s;
    logic                      accept_s;
    logic                      fwd_beat_s;
    logic                      drop_beat_s;
    logic [IDX_W-1:0]          dest_s;

    // Port lookup: an out-of-range index never matches, so it reads as disabled.
    always_comb begin
        port_en_s   = 1'b0;
        out_ready_s = 1'b0;
        m_tvalid_o  = '0;
        for (int i = 0; i < NUM_EGR_PORTS; i++) begin
            port_en_s     = port_en_s   | (egr_port_enable_i[i] & (s_tuser_i == IDX_W'(i)));
            out_ready_s   = out_ready_s | (m_tready_i[i] & (out_sel_q == IDX_W'(i)));
            m_tvalid_o[i] = out_valid_q & (out_sel_q == IDX_W'(i));
        end
    end

    assign s_tready_s = !reset_i && ((state_q == ST_DROP) || !out_valid_q || out_ready_s);
    assign accept_s   = s_tvalid_i && s_tready_s;

    // Packet FSM: routing is decided on the first beat and held until tlast.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        dest_s      = sel_q;
        fwd_beat_s  = 1'b0;
        drop_beat_s = 1'b0;
        case (state_q)
            ST_SOP: begin
                if (accept_s) begin
                    if (port_en_s) begin
                        fwd_beat_s = 1'b1;
                        dest_s     = s_tuser_i;
                        sel_d      = s_tuser_i;
                        state_d    = s_tlast_i ? ST_SOP : ST_FWD;
                    end else begin
                        drop_beat_s = 1'b1;
                        state_d     = s_tlast_i ? ST_SOP : ST_DROP;
                    end
                end else begin
                    state_d = ST_SOP;
                end
            end
            ST_FWD: begin
                if (accept_s) begin
                    fwd_beat_s = 1'b1;
                    state_d    = s_tlast_i ? ST_SOP : ST_FWD;
                end else begin
                    state_d = ST_FWD;
                end
            end
            ST_DROP: begin
                if (accept_s) begin
                    drop_beat_s = 1'b1;
                    state_d     = s_tlast_i ? ST_SOP : ST_DROP;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_SOP;
            end
        endcase
    end

    // Output stage: a load may coincide with the drain of the previous beat.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        data_d      = data_q;
        keep_d      = keep_q;
        last_d      = last_q;
        if (fwd_beat_s) begin
            out_valid_d = 1'b1;
            out_sel_d   = dest_s;
            data_d      = s_tdata_i;
            keep_d      = s_tkeep_i;
            last_d      = s_tlast_i;
        end else if (out_valid_q && out_ready_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    assign fwd_cnt_d    = (fwd_beat_s && s_tlast_i && (fwd_cnt_q != 32'hFFFF_FFFF))
                          ? (fwd_cnt_q + 32'd1) : fwd_cnt_q;
    assign drop_cnt_d   = (drop_beat_s && s_tlast_i && (drop_cnt_q != 32'hFFFF_FFFF))
                          ? (drop_cnt_q + 32'd1) : drop_cnt_q;
    assign drop_pulse_d = drop_beat_s && s_tlast_i;

    // State, output stage and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_SOP;
            sel_q        <= '0;
            out_valid_q  <= 1'b0;
            out_sel_q    <= '0;
            data_q       <= '0;
            keep_q       <= '0;
            last_q       <= 1'b0;
            fwd_cnt_q    <= 32'd0;
            drop_cnt_q   <= 32'd0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            out_valid_q  <= out_valid_d;
            out_sel_q    <= out_sel_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            last_q       <= last_d;
            fwd_cnt_q    <= fwd_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    assign s_tready_o       = s_tready_s;
    assign m_tdata_o        = data_q;
    assign m_tkeep_o        = keep_q;
    assign m_tlast_o        = last_q;
    assign fwd_pkt_count_o  = fwd_cnt_q;
    assign drop_pkt_count_o = drop_cnt_q;
    assign drop_pulse_o     = drop_pulse_q;

endmodule

// File: tb/tb_mpls_egress_demux.sv
// Directed table-driven bench for mpls_egress_demux (4 ports, 4-byte bus,
// 3-bit index so out-of-range destinations can be expressed).
module tb_mpls_egress_demux;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        s_tvalid_i;
    logic        s_tready_o;
    logic [31:0] s_tdata_i;
    logic [3:0]  s_tkeep_i;
    logic        s_tlast_i;
    logic [2:0]  s_tuser_i;
    logic [3:0]  egr_port_enable_i;
    logic [3:0]  m_tvalid_o;
    logic [3:0]  m_tready_i;
    logic [31:0] m_tdata_o;
    logic [3:0]  m_tkeep_o;
    logic        m_tlast_o;
    logic [31:0] fwd_pkt_count_o;
    logic [31:0] drop_pkt_count_o;
    logic        drop_pulse_o;

    int tests = 0;
    int fails = 0;

    mpls_egress_demux #(
        .NUM_EGR_PORTS(4),
        .DATA_BYTES(4),
        .IDX_W(3)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .s_tvalid_i(s_tvalid_i),
        .s_tready_o(s_tready_o),
        .s_tdata_i(s_tdata_i),
        .s_tkeep_i(s_tkeep_i),
        .s_tlast_i(s_tlast_i),
        .s_tuser_i(s_tuser_i),
        .egr_port_enable_i(egr_port_enable_i),
        .m_tvalid_o(m_tvalid_o),
        .m_tready_i(m_tready_i),
        .m_tdata_o(m_tdata_o),
        .m_tkeep_o(m_tkeep_o),
        .m_tlast_o(m_tlast_o),
        .fwd_pkt_count_o(fwd_pkt_count_o),
        .drop_pkt_count_o(drop_pkt_count_o),
        .drop_pulse_o(drop_pulse_o)
    );

    always #5 clk = ~clk;

    // Inputs for the coming rising edge, expected outputs as seen before it.
    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic [3:0]  kp;
        logic        lst;
        logic [2:0]  usr;
        logic [3:0]  en;
        logic [3:0]  rdy;
        logic [3:0]  e_mv;
        logic        e_srdy;
        logic [31:0] e_dat;
        logic [3:0]  e_kp;
        logic        e_lst;
        logic [31:0] e_fwd;
        logic [31:0] e_drop;
        logic        e_pulse;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic vld, input logic [31:0] dat, input logic [3:0] kp,
                                input logic lst, input logic [2:0] usr, input logic [3:0] en,
                                input logic [3:0] rdy, input logic [3:0] e_mv, input logic e_srdy,
                                input logic [31:0] e_dat, input logic [3:0] e_kp, input logic e_lst,
                                input logic [31:0] e_fwd, input logic [31:0] e_drop,
                                input logic e_pulse);
        vec_t v;
        v.vld = vld; v.dat = dat; v.kp = kp; v.lst = lst; v.usr = usr; v.en = en; v.rdy = rdy;
        v.e_mv = e_mv; v.e_srdy = e_srdy; v.e_dat = e_dat; v.e_kp = e_kp; v.e_lst = e_lst;
        v.e_fwd = e_fwd; v.e_drop = e_drop; v.e_pulse = e_pulse;
        return v;
    endfunction

    function automatic vec_t idle(input logic [3:0] e_mv, input logic [31:0] e_dat,
                                  input logic [3:0] e_kp, input logic e_lst,
                                  input logic [31:0] e_fwd, input logic [31:0] e_drop,
                                  input logic e_pulse);
        return mk(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 4'hF, 4'hF,
                  e_mv, 1'b1, e_dat, e_kp, e_lst, e_fwd, e_drop, e_pulse);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset_i           = 1'b0;
        s_tvalid_i        = v.vld;
        s_tdata_i         = v.dat;
        s_tkeep_i         = v.kp;
        s_tlast_i         = v.lst;
        s_tuser_i         = v.usr;
        egr_port_enable_i = v.en;
        m_tready_i        = v.rdy;
        #1;
        check({tag, ".m_tvalid"}, 32'(m_tvalid_o), 32'(v.e_mv));
        check({tag, ".s_tready"}, 32'(s_tready_o), 32'(v.e_srdy));
        if (v.e_mv != 4'h0) begin
            check({tag, ".m_tdata"}, m_tdata_o, v.e_dat);
            check({tag, ".m_tkeep"}, 32'(m_tkeep_o), 32'(v.e_kp));
            check({tag, ".m_tlast"}, 32'(m_tlast_o), 32'(v.e_lst));
        end
        check({tag, ".fwd_cnt"}, fwd_pkt_count_o, v.e_fwd);
        check({tag, ".drop_cnt"}, drop_pkt_count_o, v.e_drop);
        check({tag, ".drop_pulse"}, 32'(drop_pulse_o), 32'(v.e_pulse));
    endtask

    initial begin
        // 3-beat packet to port 2, then back-to-back 2-beat packets to ports 0 and 3
        tbl[0]  = idle(4'h0, 32'h0, 4'h0, 1'b0, 32'd0, 32'd0, 1'b0);
        tbl[1]  = mk(1'b1, 32'hA000_0001, 4'hF, 1'b0, 3'd2, 4'hF, 4'hF, 4'h0, 1'b1, 32'h0,        4'h0, 1'b0, 32'd0, 32'd0, 1'b0);
        tbl[2]  = mk(1'b1, 32'hA000_0002, 4'hF, 1'b0, 3'd2, 4'hF, 4'hF, 4'h4, 1'b1, 32'hA000_0001, 4'hF, 1'b0, 32'd0, 32'd0, 1'b0);
        tbl[3]  = mk(1'b1, 32'hA000_0003, 4'h3, 1'b1, 3'd2, 4'hF, 4'hF, 4'h4, 1'b1, 32'hA000_0002, 4'hF, 1'b0, 32'd0, 32'd0, 1'b0);
        tbl[4]  = mk(1'b1, 32'hB000_0001, 4'hF, 1'b0, 3'd0, 4'hF, 4'hF, 4'h4, 1'b1, 32'hA000_0003, 4'h3, 1'b1, 32'd1, 32'd0, 1'b0);
        tbl[5]  = mk(1'b1, 32'hB000_0002, 4'h3, 1'b1, 3'd3, 4'hF, 4'hF, 4'h1, 1'b1, 32'hB000_0001, 4'hF, 1'b0, 32'd1, 32'd0, 1'b0);
        tbl[6]  = mk(1'b1, 32'hC000_0001, 4'hF, 1'b0, 3'd3, 4'hF, 4'hF, 4'h1, 1'b1, 32'hB000_0002, 4'h3, 1'b1, 32'd2, 32'd0, 1'b0);
        tbl[7]  = mk(1'b1, 32'hC000_0002, 4'h3, 1'b1, 3'd0, 4'hF, 4'hF, 4'h8, 1'b1, 32'hC000_0001, 4'hF, 1'b0, 32'd2, 32'd0, 1'b0);
        // Out-of-range destination, then a packet to a disabled port
        tbl[8]  = mk(1'b1, 32'hD000_0001, 4'hF, 1'b0, 3'd5, 4'hF, 4'hF, 4'h8, 1'b1, 32'hC000_0002, 4'h3, 1'b1, 32'd3, 32'd0, 1'b0);
        tbl[9]  = mk(1'b1, 32'hD000_0002, 4'h3, 1'b1, 3'd5, 4'hF, 4'hF, 4'h0, 1'b1, 32'h0,        4'h0, 1'b0, 32'd3, 32'd0, 1'b0);
        tbl[10] = mk(1'b1, 32'hE000_0001, 4'hF, 1'b0, 3'd1, 4'hD, 4'hF, 4'h0, 1'b1, 32'h0,        4'h0, 1'b0, 32'd3, 32'd1, 1'b1);
        tbl[11] = mk(1'b1, 32'hE000_0002, 4'h3, 1'b1, 3'd1, 4'hF, 4'hF, 4'h0, 1'b1, 32'h0,        4'h0, 1'b0, 32'd3, 32'd1, 1'b0);
        tbl[12] = idle(4'h0, 32'h0, 4'h0, 1'b0, 32'd3, 32'd2, 1'b1);
        // Enables dropped mid-packet must not disturb the packet in flight
        tbl[13] = mk(1'b1, 32'hF000_0001, 4'hF, 1'b0, 3'd2, 4'hF, 4'hF, 4'h0, 1'b1, 32'h0,        4'h0, 1'b0, 32'd3, 32'd2, 1'b0);
        tbl[14] = mk(1'b1, 32'hF000_0002, 4'h3, 1'b1, 3'd2, 4'h0, 4'hF, 4'h4, 1'b1, 32'hF000_0001, 4'hF, 1'b0, 32'd3, 32'd2, 1'b0);
        tbl[15] = idle(4'h4, 32'hF000_0002, 4'h3, 1'b1, 32'd4, 32'd2, 1'b0);
        tbl[16] = idle(4'h0, 32'h0, 4'h0, 1'b0, 32'd4, 32'd2, 1'b0);
        // Port 1 stalled for 5 cycles while port 0 stays ready
        tbl[17] = mk(1'b1, 32'h6000_0001, 4'hF, 1'b0, 3'd1, 4'hF, 4'hD, 4'h0, 1'b1, 32'h0,        4'h0, 1'b0, 32'd4, 32'd2, 1'b0);
        for (int i = 18; i < 22; i++) begin
            tbl[i] = mk(1'b1, 32'h6000_0002, 4'hF, 1'b0, 3'd1, 4'hF, 4'hD, 4'h2, 1'b0, 32'h6000_0001, 4'hF, 1'b0, 32'd4, 32'd2, 1'b0);
        end
        tbl[22] = mk(1'b1, 32'h6000_0002, 4'hF, 1'b0, 3'd1, 4'hF, 4'hF, 4'h2, 1'b1, 32'h6000_0001, 4'hF, 1'b0, 32'd4, 32'd2, 1'b0);
        tbl[23] = mk(1'b1, 32'h6000_0003, 4'h3, 1'b1, 3'd1, 4'hF, 4'hF, 4'h2, 1'b1, 32'h6000_0002, 4'hF, 1'b0, 32'd4, 32'd2, 1'b0);
        tbl[24] = idle(4'h2, 32'h6000_0003, 4'h3, 1'b1, 32'd5, 32'd2, 1'b0);
        tbl[25] = idle(4'h0, 32'h0, 4'h0, 1'b0, 32'd5, 32'd2, 1'b0);

        reset_i = 1'b1; s_tvalid_i = 1'b0; s_tdata_i = 32'h0; s_tkeep_i = 4'h0;
        s_tlast_i = 1'b0; s_tuser_i = 3'd0; egr_port_enable_i = 4'hF; m_tready_i = 4'hF;
        @(negedge clk);
        #1;
        check("reset.s_tready", 32'(s_tready_o), 32'd0);
        check("reset.m_tvalid", 32'(m_tvalid_o), 32'd0);
        check("reset.fwd_cnt", fwd_pkt_count_o, 32'd0);

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // Reset lands on beat 2 of a 4-beat packet to port 3
        apply(mk(1'b1, 32'h7000_0001, 4'hF, 1'b0, 3'd3, 4'hF, 4'hF, 4'h0, 1'b1, 32'h0, 4'h0, 1'b0, 32'd5, 32'd2, 1'b0), "rst_b1");
        @(negedge clk);
        reset_i = 1'b1; s_tvalid_i = 1'b1; s_tdata_i = 32'h7000_0002; s_tlast_i = 1'b0;
        #1;
        check("rst_b2.s_tready", 32'(s_tready_o), 32'd0);
        check("rst_b2.m_tvalid", 32'(m_tvalid_o), 32'h8);
        apply(idle(4'h0, 32'h0, 4'h0, 1'b0, 32'd0, 32'd0, 1'b0), "rst_after");
        apply(mk(1'b1, 32'h8000_0001, 4'h3, 1'b1, 3'd0, 4'hF, 4'hF, 4'h0, 1'b1, 32'h0, 4'h0, 1'b0, 32'd0, 32'd0, 1'b0), "rst_pkt0");
        apply(mk(1'b1, 32'h8000_0002, 4'h7, 1'b1, 3'd2, 4'hF, 4'hF, 4'h1, 1'b1, 32'h8000_0001, 4'h3, 1'b1, 32'd1, 32'd0, 1'b0), "rst_pkt2");
        apply(idle(4'h4, 32'h8000_0002, 4'h7, 1'b1, 32'd2, 32'd0, 1'b0), "rst_done");

        // Preload the forward counter near saturation
        @(negedge clk);
        s_tvalid_i = 1'b0;
        force dut.fwd_cnt_d = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.fwd_cnt_d;
        #1;
        check("sat.preload", fwd_pkt_count_o, 32'hFFFF_FFFE);
        apply(mk(1'b1, 32'h9000_0001, 4'hF, 1'b1, 3'd0, 4'hF, 4'hF, 4'h0, 1'b1, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFFE, 32'd0, 1'b0), "sat_p1");
        apply(mk(1'b1, 32'h9000_0002, 4'hF, 1'b1, 3'd0, 4'hF, 4'hF, 4'h1, 1'b1, 32'h9000_0001, 4'hF, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0), "sat_p2");
        apply(mk(1'b1, 32'h9000_0003, 4'hF, 1'b1, 3'd0, 4'hF, 4'hF, 4'h1, 1'b1, 32'h9000_0002, 4'hF, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0), "sat_p3");
        apply(idle(4'h1, 32'h9000_0003, 4'hF, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0), "sat_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
